// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch/decode decoupling queue.
// Optional zero-latency passthrough is enabled by defining IF_ID_BYPASS_EN.
package if_id_queue_pkg;

    localparam int unsigned INS_WIDTH   = 32;
    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned ENTRY_WIDTH = INS_WIDTH + PC_WIDTH;

    localparam logic [INS_WIDTH-1:0] NOP_INS = 32'h0;

    typedef struct packed {
        logic [INS_WIDTH-1:0] ins;
        logic [PC_WIDTH-1:0]  next_pc;
    } entry_t;

endpackage

// File: rtl/if_id_queue.sv
// FIFO between fetch and decode: stalls fetch when full, drops everything on flush.
// Define IF_ID_BYPASS_EN for combinational passthrough when the queue is empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned PTR_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INS_WIDTH-1:0] if_ins,
    input  logic [PC_WIDTH-1:0]  if_next_pc,
    input  logic                 if_valid,
    input  logic                 flush,
    output logic                 pc_stall,
    input  logic                 id_ready,
    output logic                 id_valid,
    output logic [INS_WIDTH-1:0] id_ins,
    output logic [PC_WIDTH-1:0]  id_next_pc,
    output logic [PTR_BITS:0]    count
);

    localparam logic [PTR_BITS:0] CNT_FULL = (PTR_BITS + 1)'(DEPTH);

    entry_t              r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS:0]   r_count;

    logic   w_full;
    logic   w_empty;
    logic   w_bypass;
    logic   w_push;
    logic   w_pop;
    entry_t w_head;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

`ifdef IF_ID_BYPASS_EN
    assign w_bypass = w_empty & if_valid & id_ready & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed pair is consumed by decode directly and never stored.
    assign w_push = if_valid & ~w_full & ~flush & ~w_bypass;
    assign w_pop  = ~w_empty & id_ready & ~flush;
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        id_valid   = ~w_empty;
        id_ins     = NOP_INS;
        id_next_pc = '0;
        if (!w_empty) begin
            id_ins     = w_head.ins;
            id_next_pc = w_head.next_pc;
        end else if (w_bypass) begin
            id_valid   = 1'b1;
            id_ins     = if_ins;
            id_next_pc = if_next_pc;
        end
    end

    assign pc_stall = w_full;
    assign count    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left stale; the empty-state NOP mux hides it.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{ins: if_ins, next_pc: if_next_pc};
                r_wr_ptr        <= r_wr_ptr + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_BITS + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_BITS + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2).
// Bypass expectations follow IF_ID_BYPASS_EN when it is defined for the build.
module tb_if_id_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_ins;
    logic [31:0] if_next_pc;
    logic        if_valid;
    logic        flush;
    logic        pc_stall;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_next_pc;
    logic [1:0]  count;

    int checks;
    int failures;

    if_id_queue #(
        .DEPTH    (2),
        .PTR_BITS (1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_ins     (if_ins),
        .if_next_pc (if_next_pc),
        .if_valid   (if_valid),
        .flush      (flush),
        .pc_stall   (pc_stall),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_ins     (id_ins),
        .id_next_pc (id_next_pc),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        if_ins     = '0;
        if_next_pc = '0;
        if_valid   = 1'b0;
        flush      = 1'b0;
        id_ready   = 1'b0;
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_valid", 64'(id_valid), 64'd0);
        check("reset_ins", 64'(id_ins), 64'd0);
        check("reset_stall", 64'(pc_stall), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of operation
        if_valid = 1'b1; if_ins = 32'h05110003; if_next_pc = 32'd4;
        tick();
        if_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd1);
        check("pre_rst_ins", 64'(id_ins), 64'h05110003);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid", 64'(id_valid), 64'd0);
        check("async_rst_ins", 64'(id_ins), 64'd0);
        check("async_rst_stall", 64'(pc_stall), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill to full, third instruction must not be captured
        if_valid = 1'b1; if_ins = 32'h05110003; if_next_pc = 32'd4;
        tick();
        if_ins = 32'h05190005; if_next_pc = 32'd8;
        tick();
        check("full_count", 64'(count), 64'd2);
        check("full_stall", 64'(pc_stall), 64'd1);
        check("full_ins", 64'(id_ins), 64'h05110003);
        check("full_pc", 64'(id_next_pc), 64'd4);
        if_ins = 32'h02a26000; if_next_pc = 32'd12;
        tick();
        check("full_hold_count", 64'(count), 64'd2);
        check("full_hold_ins", 64'(id_ins), 64'h05110003);

        // Pop while full: no same-cycle push
        id_ready = 1'b1;
        tick();
        check("popfull_count", 64'(count), 64'd1);
        check("popfull_stall", 64'(pc_stall), 64'd0);
        check("popfull_ins", 64'(id_ins), 64'h05190005);
        check("popfull_pc", 64'(id_next_pc), 64'd8);
        id_ready = 1'b0;
        tick();
        check("refill_count", 64'(count), 64'd2);
        check("refill_ins", 64'(id_ins), 64'h05190005);

        // Flush drops queue and the flush-cycle instruction
        id_ready = 1'b1; if_ins = 32'hdeadbeef; if_next_pc = 32'd16; flush = 1'b1;
        tick();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(id_valid), 64'd0);
        check("flush_ins", 64'(id_ins), 64'd0);
        check("flush_pc", 64'(id_next_pc), 64'd0);
        check("flush_stall", 64'(pc_stall), 64'd0);
        tick();
        check("flush_after_count", 64'(count), 64'd0);
        check("flush_after_ins", 64'(id_ins), 64'd0);

        // Streaming at one instruction per cycle, pointers wrap several times
        if_valid = 1'b1; id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_ins     = 32'h00001000 + 32'(i);
            if_next_pc = 32'h00000100 + 32'(4 * i);
`ifdef IF_ID_BYPASS_EN
            #1;
            check("stream_byp_valid", 64'(id_valid), 64'd1);
            check("stream_byp_ins", 64'(id_ins), 64'(32'h00001000 + 32'(i)));
            tick();
            check("stream_byp_count", 64'(count), 64'd0);
`else
            tick();
            check("stream_count", 64'(count), 64'd1);
            check("stream_ins", 64'(id_ins), 64'(32'h00001000 + 32'(i)));
            check("stream_pc", 64'(id_next_pc), 64'(32'h00000100 + 32'(4 * i)));
`endif
        end
        if_valid = 1'b0;
        tick();
        check("stream_drain_count", 64'(count), 64'd0);
        check("stream_drain_valid", 64'(id_valid), 64'd0);

        // Empty queue with ready decode: passthrough only when bypass is built in
        if_valid = 1'b1; id_ready = 1'b1; if_ins = 32'h02eb4000; if_next_pc = 32'h200;
        #1;
`ifdef IF_ID_BYPASS_EN
        check("bypass_valid", 64'(id_valid), 64'd1);
        check("bypass_ins", 64'(id_ins), 64'h02eb4000);
        check("bypass_count", 64'(count), 64'd0);
        tick();
        check("bypass_after_count", 64'(count), 64'd0);
`else
        check("nobypass_valid", 64'(id_valid), 64'd0);
        check("nobypass_ins", 64'(id_ins), 64'd0);
        tick();
        check("nobypass_count", 64'(count), 64'd1);
        check("nobypass_ins_late", 64'(id_ins), 64'h02eb4000);
`endif
        if_valid = 1'b0;
        tick();
        check("final_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
